// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - PC, condition flags and issue/flush/memory-stall control for the vector core
// Optional feature macro: SEQ_FLAG_FORWARD_EN (forward same-cycle CMP result into condition evaluation)
module pipeline_sequencer #(
    parameter int PC_BITS      = 10,
    parameter int RESET_PC     = 0,
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               instr_valid,
    input  logic               is_cmp,
    input  logic [1:0]         cond,
    input  logic               enable_jump,
    input  logic [PC_BITS-1:0] jump_address,
    input  logic               enable_mem,
    input  logic               flag_end,
    input  logic               cmp_valid,
    input  logic               cmp_eq,
    input  logic               cmp_gt,
    input  logic               mem_ready,
    output logic [PC_BITS-1:0] pc,
    output logic               fetch_en,
    output logic               issue_en,
    output logic               flush,
    output logic               mem_req,
    output logic               halted,
    output logic               error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RUN      = 3'd1,
        S_FLUSH    = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [1:0]         C_COND_EQ    = 2'b00;
    localparam logic [1:0]         C_COND_GT    = 2'b01;
    localparam logic [1:0]         C_COND_AL    = 2'b10;
    localparam logic [1:0]         C_COND_NE    = 2'b11;
    localparam logic [PC_BITS-1:0] C_RESET_PC   = PC_BITS'(RESET_PC);
    localparam logic [PC_BITS-1:0] C_PC_ONE     = PC_BITS'(1);
    localparam logic [2:0]         C_FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam logic [7:0]         C_MEM_LAST   = 8'(MEM_TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [PC_BITS-1:0] r_pc;
    logic               r_z;
    logic               r_gt;
    logic               r_flush;
    logic               r_mem_req;
    logic               r_halted;
    logic               r_error;
    logic [2:0]         r_flush_cnt;
    logic [7:0]         r_mem_cnt;

    logic               w_z_eval;
    logic               w_gt_eval;
    logic               w_pass;
    logic               w_issue;
    logic               w_do_end;
    logic               w_do_jump;
    logic               w_do_mem;
    logic               w_mem_timeout;
    logic               w_restart;

`ifdef SEQ_FLAG_FORWARD_EN
    // A CMP result arriving this cycle takes precedence over the stored flags
    assign w_z_eval  = cmp_valid ? cmp_eq : r_z;
    assign w_gt_eval = cmp_valid ? cmp_gt : r_gt;
`else
    // Conditions see only flags stored by earlier CMPs
    assign w_z_eval  = r_z;
    assign w_gt_eval = r_gt;
`endif

    assign w_pass = is_cmp
                  | (cond == C_COND_AL)
                  | ((cond == C_COND_EQ) &  w_z_eval)
                  | ((cond == C_COND_NE) & ~w_z_eval)
                  | ((cond == C_COND_GT) &  w_gt_eval);

    assign w_issue = (r_state == S_RUN) & instr_valid & w_pass;

    // END wins over a jump, a jump wins over a memory access
    assign w_do_end  = w_issue & flag_end;
    assign w_do_jump = w_issue & ~flag_end & enable_jump;
    assign w_do_mem  = w_issue & ~flag_end & ~enable_jump & enable_mem;

    assign w_mem_timeout = (r_state == S_MEM_WAIT) & ~mem_ready & (r_mem_cnt == C_MEM_LAST);
    assign w_restart     = start & ((r_state == S_IDLE) | (r_state == S_HALT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_RUN;
            end
            S_RUN: begin
                if (w_do_end)       w_next = S_HALT;
                else if (w_do_jump) w_next = S_FLUSH;
                else if (w_do_mem)  w_next = S_MEM_WAIT;
            end
            S_FLUSH: begin
                if (r_flush_cnt <= 3'd1) w_next = S_RUN;
            end
            S_MEM_WAIT: begin
                if (mem_ready)          w_next = S_RUN;
                else if (w_mem_timeout) w_next = S_HALT;
            end
            S_HALT: begin
                if (start) w_next = S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        fetch_en = (r_state == S_RUN);
        issue_en = w_issue;
        pc       = r_pc;
        flush    = r_flush;
        mem_req  = r_mem_req;
        halted   = r_halted;
        error    = r_error;
    end

    // Registered outputs derive from the state being entered so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush   <= 1'b0;
            r_mem_req <= 1'b0;
            r_halted  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_flush   <= w_do_jump;
            r_mem_req <= (w_next == S_MEM_WAIT);
            r_halted  <= (w_next == S_HALT);
            if (w_mem_timeout) begin
                r_error <= 1'b1;
            end else if (w_restart) begin
                r_error <= 1'b0;
            end
        end
    end

    // Condition flags: restart clears them, otherwise any valid CMP result is captured
    always_ff @(posedge clk) begin
        if (rst) begin
            r_z  <= 1'b0;
            r_gt <= 1'b0;
        end else if ((r_state == S_HALT) && start) begin
            r_z  <= 1'b0;
            r_gt <= 1'b0;
        end else if (cmp_valid) begin
            r_z  <= cmp_eq;
            r_gt <= cmp_gt;
        end
    end

    // Program counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= C_RESET_PC;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (start) r_pc <= C_RESET_PC;
                end
                S_RUN: begin
                    if (w_do_jump) begin
                        r_pc <= jump_address;
                    end else if (!w_do_end && !w_do_mem) begin
                        r_pc <= r_pc + C_PC_ONE;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ready) r_pc <= r_pc + C_PC_ONE;
                end
                default: r_pc <= r_pc;
            endcase
        end
    end

    // Flush bubble down-counter and memory wait cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt <= 3'd0;
            r_mem_cnt   <= 8'd0;
        end else begin
            if (w_do_jump) begin
                r_flush_cnt <= C_FLUSH_LOAD;
            end else if ((r_state == S_FLUSH) && (r_flush_cnt != 3'd0)) begin
                r_flush_cnt <= r_flush_cnt - 3'd1;
            end
            if ((r_state == S_MEM_WAIT) && (w_next == S_MEM_WAIT)) begin
                r_mem_cnt <= r_mem_cnt + 8'd1;
            end else begin
                r_mem_cnt <= 8'd0;
            end
        end
    end

endmodule
